// File: rtl/core_pkg.sv
// Shared types for the core pipeline.
// Fetch FSM states, fault causes and instruction size.
package core_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'd0,
        FAULT_MISALIGNED = 2'd1,
        FAULT_RANGE      = 2'd2
    } fetch_fault_e;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_unit.sv
// PC register and fetch stage of the single-cycle core.
// Zero-latency fetch, stall/redirect handling, sticky fault.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS   = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    output logic        instr_mem_req_o,
    output logic [31:0] instr_mem_addr_o,
    input  logic [31:0] instr_mem_data_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        instr_valid_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o,
    output logic [31:0] fault_addr_o,
    output logic [31:0] fetch_count_o
);

    // 33-bit limit so a 4 GiB memory still compares correctly
    localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) * 33'(INSTR_BYTES);

    fetch_state_e state_q;
    fetch_fault_e cause_q;
    logic [31:0]  pc_q;
    logic [31:0]  faddr_q;
    logic [31:0]  count_q;
    logic         fault_q;

    logic [31:0]  pc_inc;
    logic [31:0]  next_pc;
    logic         fetch;
    logic         load;
    logic         misal;
    logic         range;

    assign pc_inc  = pc_q + 32'(INSTR_BYTES);
    assign next_pc = redirect_i ? redirect_target_i : pc_inc;
    assign misal   = next_pc[1:0] != 2'b00;
    assign range   = {1'b0, next_pc} >= LIMIT;

    // Redirect overrides a stall; a plain stall holds the PC
    assign load  = redirect_i | ~stall_i;
    assign fetch = (state_q == RUN) & ~stall_i;

    assign instr_mem_req_o  = fetch;
    assign instr_mem_addr_o = pc_q;
    assign instr_valid_o    = fetch;
    assign instr_o          = fetch ? instr_mem_data_i : 32'h0;
    assign pc_o             = pc_q;
    assign pc_plus4_o       = pc_inc;
    assign fault_o          = fault_q;
    assign fault_cause_o    = cause_q;
    assign fault_addr_o     = faddr_q;
    assign fetch_count_o    = count_q;

    // FSM, PC register and fault latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            fault_q <= 1'b0;
            cause_q <= FAULT_NONE;
            faddr_q <= 32'h0;
        end else begin
            unique case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (load) begin
                        if (misal) begin
                            state_q <= HALT;
                            fault_q <= 1'b1;
                            cause_q <= FAULT_MISALIGNED;
                            faddr_q <= next_pc;
                        end else if (range) begin
                            state_q <= HALT;
                            fault_q <= 1'b1;
                            cause_q <= FAULT_RANGE;
                            faddr_q <= next_pc;
                        end else begin
                            pc_q <= next_pc;
                        end
                    end
                end
                HALT: state_q <= HALT;
                default: state_q <= BOOT;
            endcase
        end
    end

    // Saturating count of valid fetches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 32'h0;
        end else if (fetch && count_q != 32'hFFFF_FFFF) begin
            count_q <= count_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Two instances: default memory and a 4-word memory.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vec = 0;
    int bad = 0;

    logic        rst_a, stall_a, redir_a;
    logic [31:0] tgt_a;
    logic        req_a, valid_a, fault_a;
    logic [31:0] addr_a, data_a, instr_a, pc_a, pc4_a;
    logic [31:0] faddr_a, cnt_a;
    logic [1:0]  cause_a;

    logic        rst_b, stall_b, redir_b;
    logic [31:0] tgt_b;
    logic        req_b, valid_b, fault_b;
    logic [31:0] addr_b, data_b, instr_b, pc_b, pc4_b;
    logic [31:0] faddr_b, cnt_b;
    logic [1:0]  cause_b;

    assign data_a = 32'hC0DE_0000 | addr_a;
    assign data_b = 32'hBEEF_0000 | addr_b;

    fetch_unit dut_a (
        .clk               (clk),
        .reset_n           (rst_a),
        .stall_i           (stall_a),
        .redirect_i        (redir_a),
        .redirect_target_i (tgt_a),
        .instr_mem_req_o   (req_a),
        .instr_mem_addr_o  (addr_a),
        .instr_mem_data_i  (data_a),
        .instr_o           (instr_a),
        .pc_o              (pc_a),
        .pc_plus4_o        (pc4_a),
        .instr_valid_o     (valid_a),
        .fault_o           (fault_a),
        .fault_cause_o     (cause_a),
        .fault_addr_o      (faddr_a),
        .fetch_count_o     (cnt_a)
    );

    fetch_unit #(.IMEM_WORDS(4)) dut_b (
        .clk               (clk),
        .reset_n           (rst_b),
        .stall_i           (stall_b),
        .redirect_i        (redir_b),
        .redirect_target_i (tgt_b),
        .instr_mem_req_o   (req_b),
        .instr_mem_addr_o  (addr_b),
        .instr_mem_data_i  (data_b),
        .instr_o           (instr_b),
        .pc_o              (pc_b),
        .pc_plus4_o        (pc4_b),
        .instr_valid_o     (valid_b),
        .fault_o           (fault_b),
        .fault_cause_o     (cause_b),
        .fault_addr_o      (faddr_b),
        .fetch_count_o     (cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Fetch in progress on A at given pc
    task automatic fetch_a(input string tag, input logic [31:0] pc);
        chk({tag, " req"}, 32'(req_a), 32'd1);
        chk({tag, " valid"}, 32'(valid_a), 32'd1);
        chk({tag, " addr"}, addr_a, pc);
        chk({tag, " instr"}, instr_a, 32'hC0DE_0000 | pc);
    endtask

    task automatic idle_a(input string tag);
        chk({tag, " req"}, 32'(req_a), 32'd0);
        chk({tag, " valid"}, 32'(valid_a), 32'd0);
        chk({tag, " instr"}, instr_a, 32'd0);
    endtask

    task automatic fetch_b(input string tag, input logic [31:0] pc);
        chk({tag, " req"}, 32'(req_b), 32'd1);
        chk({tag, " addr"}, addr_b, pc);
        chk({tag, " instr"}, instr_b, 32'hBEEF_0000 | pc);
    endtask

    initial begin
        rst_a = 1'b0; stall_a = 1'b0; redir_a = 1'b0; tgt_a = 32'h0;
        rst_b = 1'b0; stall_b = 1'b0; redir_b = 1'b0; tgt_b = 32'h0;
        #3;
        idle_a("rst");
        chk("rst pc", pc_a, 32'h0);
        chk("rst fault", 32'(fault_a), 32'd0);
        chk("rst cause", 32'(cause_a), 32'd0);
        chk("rst faddr", faddr_a, 32'h0);
        chk("rst cnt", cnt_a, 32'h0);

        cyc();
        rst_a = 1'b1;
        #1;
        idle_a("boot");
        cyc();
        fetch_a("f0", 32'h0);
        chk("f0 pc4", pc4_a, 32'h4);
        cyc();
        fetch_a("f4", 32'h4);
        cyc();
        fetch_a("f8", 32'h8);
        cyc();
        fetch_a("f12", 32'hC);
        cyc();
        chk("cnt4", cnt_a, 32'd4);
        chk("pc16", pc_a, 32'h10);

        stall_a = 1'b1; redir_a = 1'b1; tgt_a = 32'h40;
        #1;
        idle_a("stall redir");
        cyc();
        stall_a = 1'b0; redir_a = 1'b0;
        #1;
        fetch_a("f40", 32'h40);
        chk("cnt after stall redir", cnt_a, 32'd4);

        redir_a = 1'b1; tgt_a = 32'h8;
        #1;
        fetch_a("f40 redir", 32'h40);
        cyc();
        redir_a = 1'b0; stall_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            idle_a("stall");
            chk("stall pc", pc_a, 32'h8);
            chk("stall cnt", cnt_a, 32'd5);
            cyc();
        end
        stall_a = 1'b0;
        #1;
        fetch_a("rel f8", 32'h8);
        cyc();
        fetch_a("rel f12", 32'hC);
        chk("cnt6", cnt_a, 32'd6);

        redir_a = 1'b1; tgt_a = 32'h4;
        cyc();
        tgt_a = 32'h42;
        #1;
        fetch_a("f4 misal", 32'h4);
        chk("cnt7", cnt_a, 32'd7);
        cyc();
        tgt_a = 32'h80;
        #1;
        chk("mis fault", 32'(fault_a), 32'd1);
        chk("mis cause", 32'(cause_a), 32'd1);
        chk("mis faddr", faddr_a, 32'h42);
        chk("mis pc", pc_a, 32'h4);
        chk("mis cnt", cnt_a, 32'd8);
        idle_a("halt");
        cyc();
        cyc();
        redir_a = 1'b0;
        #1;
        idle_a("halt2");
        chk("halt pc", pc_a, 32'h4);
        chk("halt cause", 32'(cause_a), 32'd1);

        #2;
        rst_a = 1'b0;
        #1;
        chk("arst fault", 32'(fault_a), 32'd0);
        chk("arst cnt", cnt_a, 32'd0);
        chk("arst pc", pc_a, 32'h0);
        chk("arst cause", 32'(cause_a), 32'd0);
        cyc();
        rst_a = 1'b1;
        #1;
        idle_a("reboot");
        cyc();
        fetch_a("refetch0", 32'h0);
        cyc();
        fetch_a("refetch4", 32'h4);

        rst_b = 1'b1;
        #1;
        chk("b boot req", 32'(req_b), 32'd0);
        cyc();
        fetch_b("b0", 32'h0);
        cyc();
        fetch_b("b4", 32'h4);
        cyc();
        fetch_b("b8", 32'h8);
        cyc();
        fetch_b("b12", 32'hC);
        chk("b pc4", pc4_b, 32'h10);
        chk("b nofault", 32'(fault_b), 32'd0);
        cyc();
        chk("b fault", 32'(fault_b), 32'd1);
        chk("b cause", 32'(cause_b), 32'd2);
        chk("b faddr", faddr_b, 32'h10);
        chk("b req", 32'(req_b), 32'd0);
        chk("b addr", addr_b, 32'hC);
        chk("b cnt", cnt_b, 32'd4);

        rst_b = 1'b0;
        cyc();
        rst_b = 1'b1;
        cyc();
        redir_b = 1'b1; tgt_b = 32'h13;
        #1;
        fetch_b("b redir", 32'h0);
        cyc();
        redir_b = 1'b0;
        #1;
        chk("b prio fault", 32'(fault_b), 32'd1);
        chk("b prio cause", 32'(cause_b), 32'd1);
        chk("b prio faddr", faddr_b, 32'h13);
        chk("b prio req", 32'(req_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
